// File: rtl/decode_writeback.sv
// Decode and writeback stage: decodes source/destination register indices from
// the fetched instruction and owns the 15-entry register file.
module decode_writeback #(
    parameter logic [3:0] RSP   = 4'h4,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cond,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val
);

    localparam int unsigned NREGS = 15;
    localparam int unsigned W     = 64;

    logic signed [W-1:0] regs [0:NREGS-1];
    logic [3:0]          srca;
    logic [3:0]          srcb;

    // Source index decode
    always_comb begin
        srca = RNONE;
        srcb = RNONE;
        case (icode)
            4'h2:             srca = rA;
            4'h4, 4'h6, 4'hA: srca = rA;
            4'h9, 4'hB:       srca = RSP;
            default:          srca = RNONE;
        endcase
        case (icode)
            4'h4, 4'h5, 4'h6:       srcb = rB;
            4'h8, 4'h9, 4'hA, 4'hB: srcb = RSP;
            default:                srcb = RNONE;
        endcase
    end

    // Destination index decode; cmovXX only targets rB when the condition holds
    always_comb begin
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'h2:                   dstE = cond ? rB : RNONE;
            4'h3, 4'h6:             dstE = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP;
            default:                dstE = RNONE;
        endcase
        case (icode)
            4'h5, 4'hB: dstM = rA;
            default:    dstM = RNONE;
        endcase
    end

    // Combinational reads, no write bypass; RNONE and out-of-range read as zero
    always_comb begin
        valA    = '0;
        valB    = '0;
        dbg_val = '0;
        if (srca != RNONE && srca < 4'(NREGS))
            valA = regs[srca];
        if (srcb != RNONE && srcb < 4'(NREGS))
            valB = regs[srcb];
        if (dbg_sel != RNONE && dbg_sel < 4'(NREGS))
            dbg_val = regs[dbg_sel];
    end

    // Writeback; when both ports target one register (popq %rsp) valM wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            if (dstE != RNONE && dstE < 4'(NREGS) && dstE != dstM)
                regs[dstE] <= $signed(valE);
            if (dstM != RNONE && dstM < 4'(NREGS))
                regs[dstM] <= $signed(valM);
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed self-checking bench for decode_writeback.
`timescale 1ns/1ps
module tb_decode_writeback;

    logic        clk;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cond;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;

    int errors = 0;
    int checks = 0;

    decode_writeback #(.RSP(4'h4), .RNONE(4'hF)) dut (
        .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB),
        .cond(cond), .valE(valE), .valM(valM), .wb_en(wb_en),
        .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic en);
        icode = ic; rA = a; rB = b; cond = c; valE = e; valM = m; wb_en = en;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setin(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
        dbg_sel = 4'd0;
        #12;
        reset = 1'b0;
        // first write right after reset release
        setin(4'h3, 4'hF, 4'h5, 1'b0, 64'hAA, 64'd0, 1'b1);
        tick();
        dbg_sel = 4'd5; #0.2;
        checks++;
        if (dbg_val !== 64'hAA) begin
            errors++; $display("FAIL first_write_reg5: got %h want %h", dbg_val, 64'hAA);
        end
        // asynchronous mid-cycle reset, visible without a clock edge
        #2;
        reset = 1'b1;
        #0.5;
        for (int i = 0; i < 15; i++) begin
            dbg_sel = 4'(i);
            #0.2;
            checks++;
            if (dbg_val !== 64'd0) begin
                errors++; $display("FAIL reset_clear_reg%0d: got %h want %h", i, dbg_val, 64'd0);
            end
        end
        // edges under reset are ignored
        setin(4'h3, 4'hF, 4'h5, 1'b0, 64'hBB, 64'd0, 1'b1);
        tick();
        dbg_sel = 4'd5; #0.2;
        checks++;
        if (dbg_val !== 64'd0) begin
            errors++; $display("FAIL reset_holds_reg5: got %h want %h", dbg_val, 64'd0);
        end
        #2;
        reset = 1'b0;
        setin(4'h3, 4'hF, 4'h5, 1'b0, 64'hCC, 64'd0, 1'b1);
        tick();
        #0.2;
        checks++;
        if (dbg_val !== 64'hCC) begin
            errors++; $display("FAIL post_reset_write_reg5: got %h want %h", dbg_val, 64'hCC);
        end
    endtask

    task automatic test_irmovq();
        setin(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'd0, 1'b1);
        dbg_sel = 4'd2;
        #1;
        checks++;
        if (dstE !== 4'd2 || dstM !== 4'hF) begin
            errors++; $display("FAIL irmovq_dst: got E=%h M=%h want E=2 M=f", dstE, dstM);
        end
        checks++;
        if (dbg_val !== 64'd0 || valB !== 64'd0) begin
            errors++; $display("FAIL irmovq_pre_edge: got dbg=%h valB=%h want 0 0", dbg_val, valB);
        end
        tick();
        checks++;
        if (dbg_val !== 64'h55) begin
            errors++; $display("FAIL irmovq_reg2: got %h want %h", dbg_val, 64'h55);
        end
    endtask

    task automatic test_cmov();
        setin(4'h2, 4'h2, 4'h3, 1'b0, 64'h55, 64'd0, 1'b1);
        dbg_sel = 4'd3;
        #1;
        checks++;
        if (dstE !== 4'hF || valA !== 64'h55) begin
            errors++; $display("FAIL cmov_nc_decode: got dstE=%h valA=%h want f 55", dstE, valA);
        end
        tick();
        checks++;
        if (dbg_val !== 64'd0) begin
            errors++; $display("FAIL cmov_nc_reg3: got %h want %h", dbg_val, 64'd0);
        end
        cond = 1'b1;
        #1;
        checks++;
        if (dstE !== 4'd3) begin
            errors++; $display("FAIL cmov_c_dstE: got %h want 3", dstE);
        end
        tick();
        checks++;
        if (dbg_val !== 64'h55) begin
            errors++; $display("FAIL cmov_c_reg3: got %h want %h", dbg_val, 64'h55);
        end
    endtask

    task automatic test_pushq();
        setin(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'd0, 1'b1);
        tick();
        setin(4'h3, 4'hF, 4'h1, 1'b0, 64'h1234, 64'd0, 1'b1);
        tick();
        setin(4'hA, 4'h1, 4'hF, 1'b0, 64'hF8, 64'd0, 1'b1);
        dbg_sel = 4'd4;
        #1;
        checks++;
        if (valA !== 64'h1234 || valB !== 64'h100) begin
            errors++; $display("FAIL pushq_operands: got valA=%h valB=%h want 1234 100", valA, valB);
        end
        checks++;
        if (dstE !== 4'd4 || dstM !== 4'hF) begin
            errors++; $display("FAIL pushq_dst: got E=%h M=%h want E=4 M=f", dstE, dstM);
        end
        checks++;
        if (dbg_val !== 64'h100) begin
            errors++; $display("FAIL pushq_pre_edge_reg4: got %h want %h", dbg_val, 64'h100);
        end
        tick();
        checks++;
        if (dbg_val !== 64'hF8) begin
            errors++; $display("FAIL pushq_reg4: got %h want %h", dbg_val, 64'hF8);
        end
    endtask

    task automatic test_popq();
        setin(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h77, 1'b1);
        dbg_sel = 4'd4;
        #1;
        checks++;
        if (dstE !== 4'd4 || dstM !== 4'd4 || valA !== 64'hF8 || valB !== 64'hF8) begin
            errors++; $display("FAIL popq_rsp_decode: got E=%h M=%h valA=%h valB=%h want 4 4 f8 f8",
                               dstE, dstM, valA, valB);
        end
        tick();
        checks++;
        if (dbg_val !== 64'h77) begin
            errors++; $display("FAIL popq_rsp_reg4: got %h want %h", dbg_val, 64'h77);
        end
        setin(4'hB, 4'h6, 4'hF, 1'b0, 64'h80, 64'h99, 1'b1);
        #1;
        checks++;
        if (dstE !== 4'd4 || dstM !== 4'd6 || valA !== 64'h77) begin
            errors++; $display("FAIL popq_r6_decode: got E=%h M=%h valA=%h want 4 6 77", dstE, dstM, valA);
        end
        tick();
        checks++;
        if (dbg_val !== 64'h80) begin
            errors++; $display("FAIL popq_r6_reg4: got %h want %h", dbg_val, 64'h80);
        end
        dbg_sel = 4'd6; #0.2;
        checks++;
        if (dbg_val !== 64'h99) begin
            errors++; $display("FAIL popq_r6_reg6: got %h want %h", dbg_val, 64'h99);
        end
    endtask

    task automatic test_mrmovq();
        setin(4'h5, 4'h7, 4'h1, 1'b0, 64'h999, 64'hDEAD, 1'b1);
        dbg_sel = 4'd7;
        #1;
        checks++;
        if (dstE !== 4'hF || dstM !== 4'd7 || valA !== 64'd0 || valB !== 64'h1234) begin
            errors++; $display("FAIL mrmovq_decode: got E=%h M=%h valA=%h valB=%h want f 7 0 1234",
                               dstE, dstM, valA, valB);
        end
        tick();
        checks++;
        if (dbg_val !== 64'hDEAD) begin
            errors++; $display("FAIL mrmovq_reg7: got %h want %h", dbg_val, 64'hDEAD);
        end
    endtask

    task automatic test_back_to_back();
        setin(4'h6, 4'h1, 4'h2, 1'b0, 64'h10, 64'd0, 1'b1);
        tick();
        setin(4'h6, 4'h2, 4'h3, 1'b0, 64'h20, 64'd0, 1'b1);
        dbg_sel = 4'd3;
        #1;
        checks++;
        if (valA !== 64'h10 || valB !== 64'h55) begin
            errors++; $display("FAIL b2b_operands: got valA=%h valB=%h want 10 55", valA, valB);
        end
        tick();
        checks++;
        if (dbg_val !== 64'h20) begin
            errors++; $display("FAIL b2b_reg3: got %h want %h", dbg_val, 64'h20);
        end
    endtask

    task automatic test_nowrite();
        logic [63:0] expv [15];
        logic [3:0]  ics  [7];
        expv = '{64'd0, 64'h1234, 64'h10, 64'h20, 64'h80, 64'hCC, 64'h99, 64'hDEAD,
                 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        ics  = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
        setin(4'h6, 4'hF, 4'h2, 1'b0, 64'h1111, 64'h2222, 1'b0);
        dbg_sel = 4'd2;
        #1;
        checks++;
        if (dstE !== 4'd2 || dstM !== 4'hF || valA !== 64'd0 || valB !== 64'h10) begin
            errors++; $display("FAIL opq_wben0_decode: got E=%h M=%h valA=%h valB=%h want 2 f 0 10",
                               dstE, dstM, valA, valB);
        end
        repeat (3) tick();
        checks++;
        if (dbg_val !== 64'h10) begin
            errors++; $display("FAIL opq_wben0_reg2: got %h want %h", dbg_val, 64'h10);
        end
        for (int k = 0; k < 7; k++) begin
            setin(ics[k], 4'h1, 4'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
            #1;
            checks++;
            if (dstE !== 4'hF || dstM !== 4'hF || valA !== 64'd0 || valB !== 64'd0) begin
                errors++; $display("FAIL nowrite_decode_icode%h: got E=%h M=%h valA=%h valB=%h want f f 0 0",
                                   ics[k], dstE, dstM, valA, valB);
            end
            repeat (3) tick();
        end
        // rB = RNONE never writes
        setin(4'h3, 4'hF, 4'hF, 1'b0, 64'h5A5A, 64'd0, 1'b1);
        tick();
        setin(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            dbg_sel = 4'(i);
            #0.2;
            checks++;
            if (dbg_val !== expv[i]) begin
                errors++; $display("FAIL final_reg%0d: got %h want %h", i, dbg_val, expv[i]);
            end
        end
        dbg_sel = 4'hF;
        #0.2;
        checks++;
        if (dbg_val !== 64'd0) begin
            errors++; $display("FAIL dbg_rnone: got %h want %h", dbg_val, 64'd0);
        end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_cmov();
        test_pushq();
        test_popq();
        test_mrmovq();
        test_back_to_back();
        test_nowrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
